// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: default widths and the TX issue FSM encoding.
package uart_tx_fifo_pkg;
  localparam int DEPTH_DEF       = 16;
  localparam int DATA_BIT_DEF    = 8;
  localparam int ACK_TIMEOUT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side push/flush/status bundle plus the UART data_in/write_en/write_busy handshake.
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int DATA_BIT = DATA_BIT_DEF
) ();
  logic                      wr_en;
  logic [DATA_BIT-1:0]       wr_data;
  logic                      flush;
  logic                      full;
  logic                      empty;
  logic [$clog2(DEPTH):0]    count;
  logic                      overflow;
  logic [DATA_BIT-1:0]       uart_data_in;
  logic                      uart_write_en;
  logic                      uart_write_busy;

  modport master (
    output wr_en, wr_data, flush, uart_write_busy,
    input  full, empty, count, overflow, uart_data_in, uart_write_en
  );

  modport slave (
    input  wr_en, wr_data, flush, uart_write_busy,
    output full, empty, count, overflow, uart_data_in, uart_write_en
  );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Generic single-clock FIFO: wrap-bit pointers, registered full/empty/count, sticky overflow.
// Full is the registered value, so a push while full is dropped even if a pop happens that cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] wr_ptr_nxt, rd_ptr_nxt, cnt_nxt;
  logic        do_push, do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_comb begin
    wr_ptr_nxt = wr_ptr + (AW+1)'(do_push);
    rd_ptr_nxt = flush ? wr_ptr : rd_ptr + (AW+1)'(do_pop);
    cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= cnt_nxt;
      full   <= (cnt_nxt == FULL_CNT);
      empty  <= (cnt_nxt == '0);
      if (flush)
        overflow <= 1'b0;
      else if (push && full)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers producer bytes and issues them one at a time to the UART, re-issuing a byte
// whose write_en pulse was not acknowledged by write_busy within ACK_TIMEOUT cycles.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int DATA_BIT    = DATA_BIT_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_fifo_if.slave   bus
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(ACK_TIMEOUT);

  tx_state_t           state, state_nxt;
  logic [TW-1:0]       tmo, tmo_nxt;
  logic [DATA_BIT-1:0] data_q, data_nxt, head;
  logic                wen_q, wen_nxt;
  logic                pop, fifo_empty;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_BIT)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop),
    .flush     (bus.flush),
    .head      (head),
    .full      (bus.full),
    .empty     (fifo_empty),
    .count     (bus.count),
    .overflow  (bus.overflow)
  );

  assign bus.empty         = fifo_empty;
  assign bus.uart_data_in  = data_q;
  assign bus.uart_write_en = wen_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tmo    <= '0;
      data_q <= '0;
      wen_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      tmo    <= tmo_nxt;
      data_q <= data_nxt;
      wen_q  <= wen_nxt;
    end
  end

  // write_en is registered, so it is high exactly while the FSM sits in ISSUE.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo;
    data_nxt  = data_q;
    wen_nxt   = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          data_nxt  = head;
          wen_nxt   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        tmo_nxt   = '0;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.uart_write_busy) begin
          state_nxt = WAIT_DONE;
        end else begin
          tmo_nxt = tmo + 1'b1;
          if (tmo_nxt == TMO_MAX) begin
            wen_nxt   = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      WAIT_DONE: begin
        if (!bus.uart_write_busy)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench: queue-based reference of FIFO contents/occupancy and a behavioural UART responder.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int ACK   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH), .DATA_BIT(DW)) bus ();
  assign bus.uart_write_busy = busy;

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_BIT(DW), .ACK_TIMEOUT(ACK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model and UART responder state
  int         m_cnt = 0;
  bit         m_ovf = 1'b0;
  logic [7:0] m_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] last_byte = 8'h00;
  bit         prev_ignored = 1'b0, ignore_next = 1'b0, prev_pulse = 1'b0;
  bit         busy_pending = 1'b0, hold_chk = 1'b0;
  int         busy_left = 0, busy_len = 3;
  int         step = 0, quiet = 0, pulses = 0, max_cnt = 0;
  int         last_acc_step = 0, last_new_pulse_step = 0, ign_step = 0, reissue_gap = 0;
  int         cnt_pre;
  logic       pulse, busy_at_edge;

  always @(posedge clk) begin
    #1;
    step++;
    pulse        = bus.uart_write_en;
    busy_at_edge = busy;
    cnt_pre      = m_cnt;
    if (rst) begin
      m_cnt = 0; m_ovf = 1'b0; m_q.delete();
      prev_ignored = 1'b0; hold_chk = 1'b0;
      chk("rst_wen", 32'(bus.uart_write_en), 0);
      chk("rst_data", 32'(bus.uart_data_in), 0);
    end else begin
      if (pulse) begin
        pulses++;
        quiet = 0;
        chk("wen_back_to_back", 32'(prev_pulse), 0);
        chk("issue_while_busy", 32'(busy_at_edge), 0);
        if (prev_ignored) begin
          chk("reissue_data", 32'(bus.uart_data_in), 32'(last_byte));
          reissue_gap = step - ign_step;
        end else if (m_q.size() == 0) begin
          chk("issue_from_empty", 32'(m_q.size()), 1);
        end else begin
          last_byte = m_q.pop_front();
          m_cnt--;
          chk("issue_data", 32'(bus.uart_data_in), 32'(last_byte));
          last_new_pulse_step = step;
        end
      end else begin
        quiet++;
      end
      if (bus.flush) begin
        m_q.delete(); m_cnt = 0; m_ovf = 1'b0;
      end else if (bus.wr_en) begin
        if (cnt_pre < DEPTH) begin
          m_q.push_back(bus.wr_data);
          m_cnt++;
          last_acc_step = step;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (hold_chk && busy_at_edge)
        chk("data_stable", 32'(bus.uart_data_in), 32'(rx_q[$]));
    end
    chk("count", 32'(bus.count), 32'(m_cnt));
    chk("empty", 32'(bus.empty), 32'(m_cnt == 0));
    chk("full", 32'(bus.full), 32'(m_cnt == DEPTH));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    prev_pulse = pulse;

    // UART: busy rises the cycle after an accepted write_en, held busy_len cycles
    if (busy_pending) begin
      busy = 1'b1; busy_left = busy_len; busy_pending = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) busy = 1'b0;
    end
    if (pulse && !rst) begin
      if (ignore_next) begin
        ignore_next = 1'b0; prev_ignored = 1'b1; ign_step = step;
      end else begin
        prev_ignored = 1'b0; hold_chk = 1'b1;
        rx_q.push_back(bus.uart_data_in);
        busy_pending = 1'b1;
      end
    end
  end

  task automatic drive(input logic we, input logic [7:0] d, input logic fl);
    @(negedge clk);
    bus.wr_en = we; bus.wr_data = d; bus.flush = fl;
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    while (!(bus.empty && !busy && !busy_pending && !ignore_next && quiet > ACK + 3) && n < 3000) begin
      drive(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk({tag, "_quiet_timeout"}, 32'(n < 3000), 1);
  endtask

  initial begin
    int nb, burst, gap, n;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.flush = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) drive(1'b0, 8'h00, 1'b0);

    // Single byte with a 20-cycle busy UART
    rx_q.delete(); pulses = 0; busy_len = 20;
    drive(1'b1, 8'hA5, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    wait_quiet("single");
    chk("single_latency", 32'(last_new_pulse_step - last_acc_step), 1);
    chk("single_pulses", 32'(pulses), 1);
    chk("single_rx_n", 32'(rx_q.size()), 1);
    chk("single_rx", 32'(rx_q[0]), 'hA5);
    chk("single_cnt", 32'(bus.count), 0);

    // Burst ordering
    rx_q.delete(); max_cnt = 0; busy_len = 3;
    for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    wait_quiet("burst");
    chk("burst_max_cnt", 32'(max_cnt), 4);
    chk("burst_rx_n", 32'(rx_q.size()), 5);
    for (int i = 0; i < 5; i++) chk("burst_rx", 32'(rx_q[i]), 32'(i + 1));

    // Overflow against a stalled UART, then flush
    rx_q.delete(); busy_len = 200;
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("ovf_full", 32'(bus.full), 1);
    chk("ovf_count", 32'(bus.count), DEPTH);
    chk("ovf_flag", 32'(bus.overflow), 1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_ovf", 32'(bus.overflow), 0);
    wait_quiet("ovf");
    chk("ovf_rx_n", 32'(rx_q.size()), 1);
    chk("ovf_rx", 32'(rx_q[0]), 'h40);

    // First write_en ignored by the UART: one re-issue, one delivery
    rx_q.delete(); pulses = 0; busy_len = 4; ignore_next = 1'b1;
    drive(1'b1, 8'h3C, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    wait_quiet("ack");
    chk("ack_pulses", 32'(pulses), 2);
    chk("ack_gap", 32'(reissue_gap), ACK + 1);
    chk("ack_rx_n", 32'(rx_q.size()), 1);
    chk("ack_rx", 32'(rx_q[0]), 'h3C);
    chk("ack_cnt", 32'(bus.count), 0);

    // Random bursts of 40 bytes, pointers wrap repeatedly
    rx_q.delete(); nb = 0;
    while (nb < 40) begin
      n = 0;
      while (m_cnt > DEPTH - 8 && n < 500) begin drive(1'b0, 8'h00, 1'b0); n++; end
      burst = $urandom_range(1, 6);
      busy_len = $urandom_range(1, 5);
      for (int j = 0; j < burst && nb < 40; j++) begin
        drive(1'b1, 8'(nb), 1'b0);
        nb++;
      end
      gap = $urandom_range(0, 20);
      repeat (gap) drive(1'b0, 8'h00, 1'b0);
    end
    drive(1'b0, 8'h00, 1'b0);
    wait_quiet("wrap");
    chk("wrap_rx_n", 32'(rx_q.size()), 40);
    for (int i = 0; i < 40; i++) chk("wrap_rx", 32'(rx_q[i]), 32'(i));
    chk("wrap_empty", 32'(bus.empty), 1);

    // Reset while waiting on busy with 3 bytes queued
    rx_q.delete(); busy_len = 20;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h60 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    n = 0;
    while (!busy && n < 100) begin drive(1'b0, 8'h00, 1'b0); n++; end
    chk("pre_rst_busy", 32'(busy), 1);
    drive(1'b0, 8'h00, 1'b0);
    chk("pre_rst_cnt", 32'(bus.count), 3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cnt", 32'(bus.count), 0);
    chk("mid_rst_wen", 32'(bus.uart_write_en), 0);
    chk("mid_rst_ovf", 32'(bus.overflow), 0);
    rst = 1'b0;
    n = 0;
    while (busy && n < 100) begin drive(1'b0, 8'h00, 1'b0); n++; end
    drive(1'b1, 8'h77, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    wait_quiet("post_rst");
    chk("post_rst_rx_n", 32'(rx_q.size()), 2);
    chk("post_rst_rx", 32'(rx_q[$]), 'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got step %0d, expected completion", step);
    $fatal(1);
  end
endmodule
